// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the receive FSM state enum, the scan-code prefix bytes and the key-event record.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DECODE
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // PS/2 frames use odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// Key-event handshake and status bundle between the PS/2 receiver and its consumer.
// master = receiver side, slave = consumer side.
interface ps2_rx_ctrl_if;

  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       frame_err;
  logic       overflow;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_break,
    output evt_ext,
    output frame_err,
    output overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_break,
    input  evt_ext,
    input  frame_err,
    input  overflow,
    output evt_ready
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Key-event FIFO (power-of-two depth); head is zero whenever the FIFO is empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ps2_evt_t push_data,
  input  logic     pop,
  output ps2_evt_t head,
  output logic     full,
  output logic     empty
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  ps2_evt_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg,  count_next;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_FULL);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes bytes, folds E0/F0 prefixes
// into key events and queues them. Define PS2_PARITY_CHK_EN to reject frames with bad parity.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  ps2_rx_ctrl_if.master      evt
);

  localparam int             TMO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  // Stage 2 of the clock chain is the synchronized level; stage 3 exists only for the edge compare.
  logic [2:0]       ps2_clk_sync_reg;
  logic [1:0]       ps2_data_sync_reg;
  logic             edge_strobe;
  logic             data_bit;

  ps2_state_e       state_reg,   state_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg,   shift_next;
  logic             parity_reg,  parity_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             ext_reg,     ext_next;
  logic             brk_reg,     brk_next;
  logic             frame_err_reg, frame_err_next;
  logic             overflow_reg,  overflow_next;
  logic             tmo_hit;
  logic             abort;
  logic             push_req;

  ps2_evt_t         push_evt;
  ps2_evt_t         head_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign edge_strobe = ps2_clk_sync_reg[2] && !ps2_clk_sync_reg[1];
  assign data_bit    = ps2_data_sync_reg[1];
  assign tmo_hit     = (tmo_cnt_reg == TMO_LAST);
  assign pop         = !fifo_empty && evt.evt_ready;
  assign push_evt    = '{ext: ext_reg, brk: brk_reg, code: shift_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_clk_sync_reg  <= '1;
      ps2_data_sync_reg <= '1;
    end else begin
      ps2_clk_sync_reg  <= {ps2_clk_sync_reg[1:0], PS2_CLK};
      ps2_data_sync_reg <= {ps2_data_sync_reg[0], PS2_DATA};
    end
  end

`ifndef PS2_PARITY_CHK_EN
  // Parity bit is captured but intentionally not acted on in this build.
  logic parity_unused;
  assign parity_unused = parity_reg;
`endif

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    parity_next    = parity_reg;
    ext_next       = ext_reg;
    brk_next       = brk_reg;
    frame_err_next = 1'b0;
    push_req       = 1'b0;
    abort          = 1'b0;
    tmo_cnt_next   = (edge_strobe || state_reg == ST_IDLE) ? '0 : tmo_cnt_reg + TMO_ONE;

    unique case (state_reg)
      ST_IDLE: begin
        bit_cnt_next = '0;
        if (edge_strobe && !data_bit) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (edge_strobe) begin
          shift_next   = {data_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = ST_PARITY;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_PARITY: begin
        if (edge_strobe) begin
          parity_next = data_bit;
          state_next  = ST_STOP;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_STOP: begin
        if (edge_strobe) begin
          if (data_bit) begin
            state_next = ST_DECODE;
          end else begin
            frame_err_next = 1'b1;
            ext_next       = 1'b0;
            brk_next       = 1'b0;
            state_next     = ST_IDLE;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_DECODE: begin
        state_next = ST_IDLE;
`ifdef PS2_PARITY_CHK_EN
        if (!odd_parity_ok(shift_reg, parity_reg)) begin
          frame_err_next = 1'b1;
          ext_next       = 1'b0;
          brk_next       = 1'b0;
        end else
`endif
        if (shift_reg == PS2_EXT_CODE) begin
          ext_next = 1'b1;
        end else if (shift_reg == PS2_BRK_CODE) begin
          brk_next = 1'b1;
        end else begin
          push_req = 1'b1;
          ext_next = 1'b0;
          brk_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (abort) begin
      frame_err_next = 1'b1;
      ext_next       = 1'b0;
      brk_next       = 1'b0;
      shift_next     = '0;
      state_next     = ST_IDLE;
    end

    overflow_next = push_req && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      tmo_cnt_reg   <= '0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      frame_err_reg <= frame_err_next;
      overflow_reg  <= overflow_next;
    end
  end

  ps2_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_evt),
    .pop       (pop),
    .head      (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = head_evt.code;
  assign evt.evt_break = head_evt.brk;
  assign evt.evt_ext   = head_evt.ext;
  assign evt.frame_err = frame_err_reg;
  assign evt.overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: a keyboard-side driver feeds frames, a reference model
// predicts events/errors, and a monitor pops and compares whatever the DUT presents.
module tb_ps2_rx_ctrl;
  import ps2_pkg::*;

  localparam int TMO   = 200;
  localparam int DEPTH = 4;
  localparam int HALF  = 8;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_ctrl_if evt_if ();

  ps2_rx_ctrl #(
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .evt      (evt_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          exp_err = 0, exp_ovf = 0, obs_err = 0, obs_ovf = 0;
  int          stop_cyc = 0, rise_cyc = -100;
  int          ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
  bit          m_ext = 1'b0, m_brk = 1'b0;
  logic [9:0]  exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: what one complete frame means to a keyboard host.
  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    if (stop_bad) begin
      exp_err++; m_ext = 1'b0; m_brk = 1'b0;
      return;
    end
`ifdef PS2_PARITY_CHK_EN
    if (par_bad) begin
      exp_err++; m_ext = 1'b0; m_brk = 1'b0;
      return;
    end
`endif
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // Drives the first nedges bits of a frame (11 = complete frame).
  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad, input int nedges);
    logic [10:0] bits;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data = bits[i];
      wait_neg(HALF / 2);
      if (i == 10) begin
        model_frame(b, par_bad, stop_bad);
        stop_cyc = cyc;
      end
      ps2_clk = 1'b0;
      wait_neg(HALF);
      ps2_clk = 1'b1;
      wait_neg(HALF / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic glitch_pulse();
    ps2_data = 1'b1;
    wait_neg(HALF / 2);
    ps2_clk = 1'b0;
    wait_neg(HALF);
    ps2_clk = 1'b1;
    wait_neg(HALF / 2);
  endtask

  task automatic checkpoint(input string tag);
    wait_neg(20);
    check({tag, "_frame_err_count"}, obs_err, exp_err);
    check({tag, "_overflow_count"}, obs_ovf, exp_ovf);
    check({tag, "_pending_events"}, exp_q.size(), 0);
    check({tag, "_evt_valid_idle"}, int'(evt_if.evt_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_evt_valid"}, int'(evt_if.evt_valid), 0);
    check({tag, "_evt_code"},  int'(evt_if.evt_code), 0);
    check({tag, "_evt_break"}, int'(evt_if.evt_break), 0);
    check({tag, "_evt_ext"},   int'(evt_if.evt_ext), 0);
    check({tag, "_frame_err"}, int'(evt_if.frame_err), 0);
    check({tag, "_overflow"},  int'(evt_if.overflow), 0);
  endtask

  task automatic monitor();
    bit         prev_hold  = 1'b0;
    bit         prev_valid = 1'b0;
    logic [9:0] prev_head  = '0;
    logic [9:0] head;
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (evt_if.frame_err) obs_err++;
        if (evt_if.overflow)  obs_ovf++;
        head = {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code};
        if (evt_if.evt_valid && !prev_valid) rise_cyc = cyc;
        if (prev_hold) begin
          check("hold_valid", int'(evt_if.evt_valid), 1);
          check("hold_stable", int'(head), int'(prev_head));
        end
        if (evt_if.evt_valid && evt_if.evt_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got 'h%0h expected none", head);
          end else begin
            exp = exp_q.pop_front();
            $display("event ext=%0b brk=%0b code=%02h", head[9], head[8], head[7:0]);
            check("event", int'(head), int'(exp));
          end
        end
        prev_hold  = evt_if.evt_valid && !evt_if.evt_ready;
        prev_head  = head;
        prev_valid = evt_if.evt_valid;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       evt_if.evt_ready = 1'b0;
        1:       evt_if.evt_ready = 1'b1;
        default: evt_if.evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         r;
    evt_if.evt_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none

    // Reset state
    wait_neg(1);
    check_all_zero("reset");
    wait_neg(2);
    rst = 1'b1;
    wait_neg(5);

    // Single frame with latency measurement
    ready_mode = 1;
    send_frame(8'h1D, 1'b0, 1'b0, 11);
    check("latency_stop_to_valid", rise_cyc - stop_cyc, 4);
    checkpoint("single");

    // Extended release
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    checkpoint("ext_break");

    // Overflow with consumer stalled
    ready_mode = 0;
    for (int i = 0; i < 5; i++) send_frame(8'h1C, 1'b0, 1'b0, 11);
    wait_neg(10);
    check("full_overflow_count", obs_ovf, exp_ovf);
    check("full_evt_valid", int'(evt_if.evt_valid), 1);
    ready_mode = 1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_neg(1);
    checkpoint("overflow_drain");

    // Timeout on a partial frame, prefix must be forgotten
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h55, 1'b0, 1'b0, 6);
    exp_err++; m_ext = 1'b0; m_brk = 1'b0;
    wait_neg(TMO + 20);
    check("timeout_frame_err", obs_err, exp_err);
    send_frame(8'h23, 1'b0, 1'b0, 11);
    checkpoint("timeout");

    // Flipped parity
    send_frame(8'h1B, 1'b1, 1'b0, 11);
    checkpoint("parity");

    // Bad stop bit and a stray clock pulse in idle
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    glitch_pulse();
    checkpoint("stop_glitch");

    // Reset mid-frame with an event queued
    ready_mode = 0;
    send_frame(8'h2A, 1'b0, 1'b0, 11);
    send_frame(8'h1D, 1'b0, 1'b0, 5);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_neg(1);
    check_all_zero("midframe_reset");
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0;
    wait_neg(3);
    rst = 1'b1;
    ready_mode = 1;
    wait_neg(5);
    check("post_reset_evt_valid", int'(evt_if.evt_valid), 0);
    send_frame(8'h1D, 1'b0, 1'b0, 11);
    checkpoint("after_reset");

    // Randomized traffic
    ready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch_pulse();
      end else begin
        r = $urandom_range(0, 5);
        if (r == 0)      b = 8'hE0;
        else if (r == 1) b = 8'hF0;
        else             b = 8'($urandom_range(0, 255));
        send_frame(b, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 11);
      end
    end
    ready_mode = 1;
    checkpoint("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 10000: clk cycles without a PS2_CLK falling edge before a partial frame is aborted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: key-event FIFO entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port PS2_CLK, input, 1: raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port PS2_DATA, input, 1: raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port evt_valid, output, 1: FIFO head holds a key event.
REQ-008 SHALL have port evt_ready, input, 1: consumer accepts the head event.
REQ-009 SHALL have port evt_code, output, 8: scan code of the head event.
REQ-010 SHALL have port evt_break, output, 1: head event is a release (preceded by 0xF0).
REQ-011 SHALL have port evt_ext, output, 1: head event is extended (preceded by 0xE0).
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on an aborted or invalid frame.
REQ-013 SHALL have port overflow, output, 1: one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-014 SHALL pass PS2_CLK and PS2_DATA through 2-flop synchronizers; a falling-edge strobe is the synchronized clock going 1->0 (third-stage compare).
REQ-015 SHALL run receive FSM states IDLE, DATA, PARITY, STOP, DECODE; all transitions except DECODE->IDLE occur only on an edge strobe.
REQ-016 IDLE: on an edge strobe with data=0, SHALL go to DATA; with data=1, SHALL stay in IDLE and raise no error.
REQ-017 DATA: SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-018 PARITY: SHALL sample the parity bit, then go to STOP.
REQ-019 STOP: data=1 SHALL go to DECODE; data=0 SHALL pulse frame_err and go to IDLE.
REQ-020 DECODE SHALL last exactly one cycle, then go to IDLE.
REQ-021 The timeout counter SHALL clear on every edge strobe and while in IDLE; in DATA, PARITY or STOP, reaching TIMEOUT_CYC-1 SHALL pulse frame_err, discard the partial byte, clear the prefix flags and go to IDLE.
REQ-022 DECODE with byte 0xE0 SHALL set the ext flag and push nothing.
REQ-023 DECODE with byte 0xF0 SHALL set the brk flag and push nothing.
REQ-024 DECODE with any other byte SHALL push {ext, brk, byte} and clear both flags.
REQ-025 Any frame_err SHALL clear both prefix flags.
REQ-026 A push into a full FIFO SHALL drop the event, pulse overflow and still clear the flags, unless a pop occurs in the same cycle, in which case the push succeeds.
REQ-027 Latency SHALL be: stop-bit edge strobe in cycle N, DECODE/push in N+1, evt_valid high in N+2 when the FIFO was empty; there is no bypass path.
REQ-028 evt_code, evt_break and evt_ext SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-029 The head SHALL pop on a cycle with evt_valid and evt_ready both high.
REQ-030 Simultaneous push and pop SHALL keep the FIFO count unchanged.

Reset
REQ-031 rst low SHALL asynchronously force: FSM to IDLE, FIFO empty, prefix flags and timeout counter to 0, synchronizer flops to 1.
REQ-032 rst low SHALL asynchronously force evt_valid, evt_code, evt_break, evt_ext, frame_err and overflow to 0.
REQ-033 A frame in progress when rst is asserted SHALL be discarded with no error pulse after release.

Configuration
REQ-034 With macro PS2_PARITY_CHK_EN defined, DECODE SHALL check odd parity over data and parity bit; on a mismatch it SHALL pulse frame_err, clear the flags and push nothing.
REQ-035 Without PS2_PARITY_CHK_EN, the parity bit SHALL be sampled and ignored.

Structure
REQ-036 Package ps2_pkg SHALL hold the FSM state enum, the constants PS2_EXT_CODE=8'hE0 and PS2_BRK_CODE=8'hF0, and the 10-bit key-event struct {ext, brk, code}.
REQ-037 The FIFO SHALL be sub-module ps2_evt_fifo, parameterized by FIFO_DEPTH, with push/pop/full/empty ports.

Verification
REQ-038 Frame 0x1D with good parity, evt_ready=1 -> one event {ext=0, brk=0, code=0x1D}, evt_valid high 2 cycles after the stop edge.
REQ-039 Frames 0xE0, 0xF0, 0x75 -> one event {ext=1, brk=1, code=0x75}; no event for the prefixes.
REQ-040 evt_ready=0, send 5 frames 0x1C with FIFO_DEPTH=4 -> 4 events held, one overflow pulse; draining yields exactly 4 events.
REQ-041 Stop after 5 data bits, then wait TIMEOUT_CYC cycles -> one frame_err pulse; the next full frame 0x23 is received correctly.
REQ-042 Frame 0x1B with a flipped parity bit -> with PS2_PARITY_CHK_EN: frame_err and no event; without the macro: event code 0x1B.
REQ-043 Assert rst mid-frame after 4 bits, then release and send 0x1D -> all outputs 0 during reset; exactly one event 0x1D and no frame_err afterwards.
